// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 GRAM controller.
// Holds the FSM state set, I2C control bytes and the init table.
package oled_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_INIT_CMD,
    S_PG_SETUP,
    S_PG_DATA,
    S_IDLE,
    S_ONOFF
  } state_e;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;
  localparam int         INIT_LEN  = 29;

  function automatic logic [7:0] init_byte(
    input logic [4:0] i
  );
    case (i)
      5'd0:    init_byte = 8'hA8;
      5'd1:    init_byte = 8'h1F;
      5'd2:    init_byte = 8'hDA;
      5'd3:    init_byte = 8'h02;
      5'd4:    init_byte = 8'hD3;
      5'd5:    init_byte = 8'h00;
      5'd6:    init_byte = 8'h40;
      5'd7:    init_byte = 8'hA1;
      5'd8:    init_byte = 8'h81;
      5'd9:    init_byte = 8'hFF;
      5'd10:   init_byte = 8'hA4;
      5'd11:   init_byte = 8'hA6;
      5'd12:   init_byte = 8'hD5;
      5'd13:   init_byte = 8'hF0;
      5'd14:   init_byte = 8'h8D;
      5'd15:   init_byte = 8'h14;
      5'd16:   init_byte = 8'hAE;
      5'd17:   init_byte = 8'h20;
      5'd18:   init_byte = 8'h02;
      5'd19:   init_byte = 8'hB0;
      5'd20:   init_byte = 8'hC8;
      5'd21:   init_byte = 8'h00;
      5'd22:   init_byte = 8'h10;
      5'd23:   init_byte = 8'h40;
      5'd24:   init_byte = 8'hD9;
      5'd25:   init_byte = 8'h22;
      5'd26:   init_byte = 8'hDB;
      5'd27:   init_byte = 8'h20;
      5'd28:   init_byte = 8'hAF;
      default: init_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_delay.sv
// Saturating power-up counter; done_o holds high once
// N-1 cycles have elapsed since reset was released.
module oled_delay #(
  parameter int unsigned N = 16_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic done_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!done_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oled_gram_ctrl.sv
// SSD1306 controller: power-up wait, init, first clear, then
// arbitrated on/off and full-frame GRAM refresh over an I2C byte port.
module oled_gram_ctrl
  import oled_pkg::*;
#(
  parameter int DELAY_CYCLES = 16_000_000,
  parameter int PAGES        = 4,
  parameter int COLS         = 128,
  parameter int AW           = $clog2(PAGES * COLS)
) (
  input  logic          clk_32M,
  input  logic          rst,
  input  logic          cmd_on,
  input  logic          cmd_off,
  input  logic          refresh,
  input  logic          fill_en,
  input  logic [7:0]    fill_pattern,
  output logic [AW-1:0] gram_addr,
  input  logic [7:0]    gram_data,
  output logic          i2c_enable,
  output logic [7:0]    i2c_ctrl,
  output logic [7:0]    i2c_data,
  input  logic          i2c_done,
  output logic          busy,
  output logic          init_done
);

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    data_q, data_d;
  logic [4:0]    idx_q, idx_d;
  logic [2:0]    page_q, page_d;
  logic [7:0]    col_q, col_d;
  logic [1:0]    sub_q, sub_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          fill_q, fill_d;
  logic [7:0]    fillb_q, fillb_d;
  logic          idone_q, idone_d;
  logic          off_q, off_d;
  logic          on_q, on_d;
  logic          ref_q, ref_d;
  logic          rfill_q, rfill_d;
  logic [7:0]    rpat_q, rpat_d;
  logic          svc_off, svc_on, svc_ref;
  logic          dly_done;
  logic          ack;
  logic [7:0]    pix;
  logic [AW-1:0] addr_inc;

  oled_delay #(
    .N (DELAY_CYCLES)
  ) u_delay (
    .clk_i  (clk_32M),
    .rst_i  (rst),
    .done_o (dly_done)
  );

  assign ack        = i2c_done & en_q;
  assign pix        = fill_q ? fillb_q : gram_data;
  assign gram_addr  = addr_q;
  assign i2c_enable = en_q;
  assign i2c_ctrl   = ctrl_q;
  assign i2c_data   = data_q;
  assign busy       = (state_q != S_IDLE);
  assign init_done  = idone_q;

  // addr_q runs one byte ahead of the column being sent
  assign addr_inc = (addr_q == AW'(PAGES * COLS - 1)) ?
                    '0 : addr_q + 1'b1;

  always_comb begin
    off_d   = off_q & ~svc_off;
    on_d    = on_q & ~svc_on;
    ref_d   = ref_q & ~svc_ref;
    rfill_d = rfill_q;
    rpat_d  = rpat_q;
    if (cmd_off) begin
      off_d = 1'b1;
      on_d  = 1'b0;
    end else if (cmd_on) begin
      on_d  = 1'b1;
      off_d = 1'b0;
    end
    if (refresh) begin
      ref_d   = 1'b1;
      rfill_d = fill_en;
      rpat_d  = fill_pattern;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    idx_d   = idx_q;
    page_d  = page_q;
    col_d   = col_q;
    sub_d   = sub_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    fillb_d = fillb_q;
    idone_d = idone_q;
    svc_off = 1'b0;
    svc_on  = 1'b0;
    svc_ref = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (dly_done) begin
          state_d = S_INIT_CMD;
          en_d    = 1'b1;
          ctrl_d  = CTRL_CMD;
          data_d  = init_byte(5'd0);
          idx_d   = '0;
        end
      end
      S_INIT_CMD: begin
        if (ack) begin
          if (idx_q == 5'(INIT_LEN - 1)) begin
            state_d = S_PG_SETUP;
            data_d  = 8'hB0;
            page_d  = '0;
            sub_d   = '0;
            addr_d  = '0;
            fill_d  = 1'b1;
            fillb_d = 8'h00;
          end else begin
            idx_d  = idx_q + 5'd1;
            data_d = init_byte(idx_q + 5'd1);
          end
        end
      end
      S_PG_SETUP: begin
        if (ack) begin
          if (sub_q == 2'd2) begin
            state_d = S_PG_DATA;
            ctrl_d  = CTRL_DATA;
            col_d   = '0;
            data_d  = pix;
            addr_d  = addr_inc;
          end else begin
            sub_d  = sub_q + 2'd1;
            data_d = (sub_q == 2'd0) ? 8'h00 : 8'h10;
          end
        end
      end
      S_PG_DATA: begin
        if (ack) begin
          if (col_q == 8'(COLS - 1)) begin
            col_d = '0;
            if (page_q == 3'(PAGES - 1)) begin
              state_d = S_IDLE;
              en_d    = 1'b0;
              page_d  = '0;
              idone_d = 1'b1;
            end else begin
              state_d = S_PG_SETUP;
              ctrl_d  = CTRL_CMD;
              sub_d   = '0;
              page_d  = page_q + 3'd1;
              data_d  = 8'hB0 | {5'd0, page_q + 3'd1};
            end
          end else begin
            col_d  = col_q + 8'd1;
            data_d = pix;
            addr_d = addr_inc;
          end
        end
      end
      S_IDLE: begin
        if (off_q) begin
          svc_off = 1'b1;
          state_d = S_ONOFF;
          en_d    = 1'b1;
          ctrl_d  = CTRL_CMD;
          data_d  = 8'hAE;
        end else if (on_q) begin
          svc_on  = 1'b1;
          state_d = S_ONOFF;
          en_d    = 1'b1;
          ctrl_d  = CTRL_CMD;
          data_d  = 8'hAF;
        end else if (ref_q) begin
          svc_ref = 1'b1;
          state_d = S_PG_SETUP;
          en_d    = 1'b1;
          ctrl_d  = CTRL_CMD;
          data_d  = 8'hB0;
          page_d  = '0;
          sub_d   = '0;
          addr_d  = '0;
          fill_d  = rfill_q;
          fillb_d = rpat_q;
        end
      end
      S_ONOFF: begin
        if (ack) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_32M) begin
    if (rst) begin
      state_q <= S_WAIT;
      en_q    <= 1'b0;
      ctrl_q  <= 8'h00;
      data_q  <= 8'h00;
      idx_q   <= '0;
      page_q  <= '0;
      col_q   <= '0;
      sub_q   <= '0;
      addr_q  <= '0;
      fill_q  <= 1'b0;
      fillb_q <= 8'h00;
      idone_q <= 1'b0;
      off_q   <= 1'b0;
      on_q    <= 1'b0;
      ref_q   <= 1'b0;
      rfill_q <= 1'b0;
      rpat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      col_q   <= col_d;
      sub_q   <= sub_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      fillb_q <= fillb_d;
      idone_q <= idone_d;
      off_q   <= off_d;
      on_q    <= on_d;
      ref_q   <= ref_d;
      rfill_q <= rfill_d;
      rpat_q  <= rpat_d;
    end
  end

endmodule

// File: tb/tb_oled_gram_ctrl.sv
// Scoreboard bench for oled_gram_ctrl: sync GRAM model and an
// I2C master model that acks each byte 20 cycles after enable.
module tb_oled_gram_ctrl;

  logic       clk_32M = 1'b0;
  logic       rst;
  logic       cmd_on, cmd_off, refresh;
  logic       fill_en;
  logic [7:0] fill_pattern;
  logic [8:0] gram_addr;
  logic [7:0] gram_data;
  logic       i2c_enable;
  logic [7:0] i2c_ctrl, i2c_data;
  logic       i2c_done;
  logic       busy, init_done;

  logic [7:0]  mem [512];
  logic [7:0]  init_tbl [29];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int          ack_cnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk_32M = ~clk_32M;

  oled_gram_ctrl #(
    .DELAY_CYCLES (1000),
    .PAGES        (4),
    .COLS         (128)
  ) dut (
    .clk_32M      (clk_32M),
    .rst          (rst),
    .cmd_on       (cmd_on),
    .cmd_off      (cmd_off),
    .refresh      (refresh),
    .fill_en      (fill_en),
    .fill_pattern (fill_pattern),
    .gram_addr    (gram_addr),
    .gram_data    (gram_data),
    .i2c_enable   (i2c_enable),
    .i2c_ctrl     (i2c_ctrl),
    .i2c_data     (i2c_data),
    .i2c_done     (i2c_done),
    .busy         (busy),
    .init_done    (init_done)
  );

  always @(posedge clk_32M) gram_data <= mem[gram_addr];

  always @(negedge clk_32M) begin
    if (rst) begin
      ack_cnt  <= 0;
      i2c_done <= 1'b0;
    end else if (i2c_done) begin
      i2c_done <= 1'b0;
      ack_cnt  <= 0;
    end else if (i2c_enable) begin
      if (ack_cnt == 19) begin
        i2c_done <= 1'b1;
        got_q.push_back({i2c_ctrl, i2c_data});
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 29; i++)
      exp_q.push_back({8'h00, init_tbl[i]});
  endtask

  task automatic push_frame(input bit f, input logic [7:0] pat);
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back({8'h00, 8'hB0 | 8'(p)});
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0010);
      for (int c = 0; c < 128; c++)
        exp_q.push_back({8'h40, f ? pat : mem[p*128+c]});
    end
  endtask

  task automatic pulse(input bit on, input bit off, input bit rf);
    @(negedge clk_32M);
    cmd_on  = on;
    cmd_off = off;
    refresh = rf;
    @(negedge clk_32M);
    cmd_on  = 1'b0;
    cmd_off = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic wait_got(input int target, input int budget);
    int n = 0;
    while (got_q.size() < target && n < budget) begin
      @(negedge clk_32M);
      n++;
    end
    chk("wait_got", 32'(n < budget), 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!(got_q.size() >= exp_q.size() && !busy &&
             !i2c_enable) && n < budget) begin
      @(negedge clk_32M);
      n++;
    end
    chk("wait_quiet", 32'(n < budget), 1);
    repeat (60) @(negedge clk_32M);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    init_tbl = '{8'hA8, 8'h1F, 8'hDA, 8'h02, 8'hD3, 8'h00, 8'h40,
                 8'hA1, 8'h81, 8'hFF, 8'hA4, 8'hA6, 8'hD5, 8'hF0,
                 8'h8D, 8'h14, 8'hAE, 8'h20, 8'h02, 8'hB0, 8'hC8,
                 8'h00, 8'h10, 8'h40, 8'hD9, 8'h22, 8'hDB, 8'h20,
                 8'hAF};
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    rst          = 1'b1;
    cmd_on       = 1'b0;
    cmd_off      = 1'b0;
    refresh      = 1'b0;
    fill_en      = 1'b0;
    fill_pattern = 8'h00;
    repeat (5) @(negedge clk_32M);
    chk("rst en", 32'(i2c_enable), 0);
    chk("rst ctrl", 32'(i2c_ctrl), 0);
    chk("rst data", 32'(i2c_data), 0);
    chk("rst busy", 32'(busy), 1);
    chk("rst idone", 32'(init_done), 0);
    chk("rst addr", 32'(gram_addr), 0);

    // power-up: first byte exactly on edge 1000
    rst = 1'b0;
    repeat (999) @(posedge clk_32M);
    #1 chk("pwr en@999", 32'(i2c_enable), 0);
    @(posedge clk_32M);
    #1 chk("pwr en@1000", 32'(i2c_enable), 1);
    chk("pwr first", {24'd0, i2c_data}, 32'hA8);
    push_init();
    push_frame(1'b1, 8'h00);
    wait_quiet(20000);
    chk("pwr idone", 32'(init_done), 1);
    chk("pwr busy", 32'(busy), 0);
    compare("pwrup");

    fill_en      = 1'b0;
    fill_pattern = 8'h5A;
    pulse(0, 0, 1);
    push_frame(1'b0, 8'h00);
    wait_quiet(15000);
    chk("p2 setup0", 32'(got_q[262]), 32'h00B2);
    chk("p2 setup1", 32'(got_q[263]), 32'h0000);
    chk("p2 setup2", 32'(got_q[264]), 32'h0010);
    chk("p2 col5", 32'(got_q[270]), 32'h4005);
    compare("refresh");

    pulse(1, 1, 0);
    exp_q.push_back(16'h00AE);
    wait_quiet(2000);
    compare("onoff");

    // fill frame; off then on while busy leaves only on pending
    fill_en      = 1'b1;
    fill_pattern = 8'hFF;
    pulse(0, 0, 1);
    push_frame(1'b1, 8'hFF);
    exp_q.push_back(16'h00AF);
    wait_got(100, 4000);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    wait_quiet(15000);
    fill_en      = 1'b0;
    fill_pattern = 8'h00;
    compare("fill");

    pulse(0, 0, 1);
    wait_got(50, 3000);
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    push_frame(1'b0, 8'h00);
    exp_q.push_back(16'h00AE);
    push_frame(1'b0, 8'h00);
    wait_quiet(30000);
    compare("queued");

    // reset during the 200th clear byte
    chk("pre idone", 32'(init_done), 1);
    @(negedge clk_32M);
    rst = 1'b1;
    @(negedge clk_32M);
    rst = 1'b0;
    got_q.delete();
    wait_got(228, 9000);
    repeat (3) @(negedge clk_32M);
    chk("mid en", 32'(i2c_enable), 1);
    push_init();
    push_frame(1'b1, 8'h00);
    for (int i = 0; i < 228; i++)
      chk($sformatf("pre[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    rst = 1'b1;
    @(posedge clk_32M);
    #1 chk("rst2 en", 32'(i2c_enable), 0);
    chk("rst2 idone", 32'(init_done), 0);
    @(negedge clk_32M);
    rst = 1'b0;
    got_q.delete();
    repeat (999) @(posedge clk_32M);
    #1 chk("rst2 en@999", 32'(i2c_enable), 0);
    @(posedge clk_32M);
    #1 chk("rst2 en@1000", 32'(i2c_enable), 1);
    chk("rst2 first", {24'd0, i2c_data}, 32'hA8);
    wait_got(3, 200);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst2[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
